// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants, FSM encoding and helpers
// for the parametrised register file and its clear sequencer.
package reg_file_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  // Ceiling log2, never below 1 so a 2-entry file still gets an address bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/reg_file_2r1w_clr_if.sv
// reg_file_2r1w_clr_if: write, read, clear and debug signals
// of the register file, grouped for the datapath.
interface reg_file_2r1w_clr_if
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = clog2(DEF_DEPTH)
);

  logic             W_en;
  logic [AW-1:0]    W_Addr;
  logic [WIDTH-1:0] W_Data;
  logic             R0_en;
  logic [AW-1:0]    R0_Addr;
  logic [WIDTH-1:0] R0_Data;
  logic             R1_en;
  logic [AW-1:0]    R1_Addr;
  logic [WIDTH-1:0] R1_Data;
  logic             Clr_Req;
  logic [WIDTH-1:0] Clr_Data;
  logic             Busy;
  logic             Clr_Done;
  logic             W_Drop;
  logic [AW-1:0]    Dbg_Addr;
  logic [WIDTH-1:0] Dbg_Data;

  modport master (
    output W_en, W_Addr, W_Data,
    output R0_en, R0_Addr, R1_en, R1_Addr,
    output Clr_Req, Clr_Data, Dbg_Addr,
    input  R0_Data, R1_Data,
    input  Busy, Clr_Done, W_Drop, Dbg_Data
  );

  modport slave (
    input  W_en, W_Addr, W_Data,
    input  R0_en, R0_Addr, R1_en, R1_Addr,
    input  Clr_Req, Clr_Data, Dbg_Addr,
    output R0_Data, R1_Data,
    output Busy, Clr_Done, W_Drop, Dbg_Data
  );

endinterface

// File: rtl/reg_file_clr_seq.sv
// reg_file_clr_seq: clear sweep FSM, one entry per cycle,
// plus done and dropped-write pulses.
module reg_file_clr_seq
  import reg_file_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Clr_Req,
  input  logic [WIDTH-1:0] Clr_Data,
  input  logic             W_en,
  output logic             Busy,
  output logic             Clr_Done,
  output logic             W_Drop,
  output logic             sw_we,
  output logic [AW-1:0]    sw_addr,
  output logic [WIDTH-1:0] sw_data
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [AW-1:0]    ptr;
  logic [WIDTH-1:0] fill;
  logic             last;

  assign last    = (ptr == LAST);
  assign sw_addr = ptr;
  assign sw_data = fill;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (Clr_Req) state_nxt = ST_SWEEP;
      ST_SWEEP: if (last)    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    Busy  = 1'b0;
    sw_we = 1'b0;
    if (state == ST_SWEEP) begin
      Busy  = 1'b1;
      sw_we = 1'b1;
    end
  end

  // Clr_Req during a sweep is neither restarted nor queued.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ptr      <= '0;
      fill     <= '0;
      Clr_Done <= 1'b0;
      W_Drop   <= 1'b0;
    end else begin
      Clr_Done <= (state == ST_SWEEP) && last;
      W_Drop   <= (state == ST_SWEEP) && W_en;
      if (state == ST_IDLE && Clr_Req) begin
        ptr  <= '0;
        fill <= Clr_Data;
      end else if (state == ST_SWEEP && !last) begin
        ptr <= ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_file_2r1w_clr.sv
// reg_file_2r1w_clr: flop register file, one write port,
// two registered write-first read ports, clear sweep, debug view.
module reg_file_2r1w_clr
  import reg_file_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic                 Clk,
  input  logic                 Rst,
  reg_file_2r1w_clr_if.slave   bus
);

  logic [WIDTH-1:0] mem [DEPTH];

  logic             sw_we;
  logic [AW-1:0]    sw_addr;
  logic [WIDTH-1:0] sw_data;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] r0_nxt;
  logic [WIDTH-1:0] r1_nxt;
  logic [WIDTH-1:0] dbg;

  reg_file_clr_seq #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_seq (
    .Clk      (Clk),
    .Rst      (Rst),
    .Clr_Req  (bus.Clr_Req),
    .Clr_Data (bus.Clr_Data),
    .W_en     (bus.W_en),
    .Busy     (bus.Busy),
    .Clr_Done (bus.Clr_Done),
    .W_Drop   (bus.W_Drop),
    .sw_we    (sw_we),
    .sw_addr  (sw_addr),
    .sw_data  (sw_data)
  );

  // Sweep owns the port; out-of-range user addresses match no entry.
  always_comb begin
    we    = bus.W_en & ~sw_we;
    waddr = bus.W_Addr;
    wdata = bus.W_Data;
    if (sw_we) begin
      we    = 1'b1;
      waddr = sw_addr;
      wdata = sw_data;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < DEPTH; i++)
        if (waddr == AW'(i)) mem[i] <= wdata;
    end
  end

  always_comb begin
    r0_nxt = '0;
    r1_nxt = '0;
    dbg    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.R0_Addr == AW'(i))
        r0_nxt = (we && waddr == AW'(i)) ? wdata : mem[i];
      if (bus.R1_Addr == AW'(i))
        r1_nxt = (we && waddr == AW'(i)) ? wdata : mem[i];
      if (bus.Dbg_Addr == AW'(i))
        dbg = mem[i];
    end
  end

  assign bus.Dbg_Data = dbg;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      bus.R0_Data <= '0;
      bus.R1_Data <= '0;
    end else begin
      if (bus.R0_en) bus.R0_Data <= r0_nxt;
      if (bus.R1_en) bus.R1_Data <= r1_nxt;
    end
  end

endmodule

// File: tb/tb_reg_file_2r1w_clr.sv
// tb_reg_file_2r1w_clr: directed vectors for a 16-entry and a
// 12-entry register file, including clear sweeps and reset abort.
module tb_reg_file_2r1w_clr;
  import reg_file_pkg::*;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 Clk = ~Clk;

  reg_file_2r1w_clr_if #(.WIDTH(8), .AW(4)) b16 ();
  reg_file_2r1w_clr_if #(.WIDTH(8), .AW(4)) b12 ();

  reg_file_2r1w_clr #(.WIDTH(8), .DEPTH(16)) u16 (
    .Clk (Clk),
    .Rst (Rst),
    .bus (b16.slave)
  );

  reg_file_2r1w_clr #(.WIDTH(8), .DEPTH(12)) u12 (
    .Clk (Clk),
    .Rst (Rst),
    .bus (b12.slave)
  );

  typedef struct {
    logic       w_en;
    logic [3:0] w_addr;
    logic [7:0] w_data;
    logic       r0_en;
    logic [3:0] r0_addr;
    logic       r1_en;
    logic [3:0] r1_addr;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    b16.W_en = 0; b16.W_Addr = 0; b16.W_Data = 0;
    b16.R0_en = 0; b16.R0_Addr = 0; b16.R1_en = 0; b16.R1_Addr = 0;
    b16.Clr_Req = 0; b16.Clr_Data = 0; b16.Dbg_Addr = 0;
    b12.W_en = 0; b12.W_Addr = 0; b12.W_Data = 0;
    b12.R0_en = 0; b12.R0_Addr = 0; b12.R1_en = 0; b12.R1_Addr = 0;
    b12.Clr_Req = 0; b12.Clr_Data = 0; b12.Dbg_Addr = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    int done_cnt;

    vt[0] = '{1'b1, 4'd3,  8'h5A, 1'b1, 4'd3,  1'b1, 4'd4,  8'h5A, 8'h00};
    vt[1] = '{1'b1, 4'd4,  8'hC3, 1'b1, 4'd3,  1'b1, 4'd4,  8'h5A, 8'hC3};
    vt[2] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd4,  1'b1, 4'd4,  8'hC3, 8'hC3};
    vt[3] = '{1'b1, 4'd3,  8'h77, 1'b0, 4'd4,  1'b1, 4'd3,  8'hC3, 8'h77};
    vt[4] = '{1'b1, 4'd15, 8'hE1, 1'b1, 4'd15, 1'b1, 4'd0,  8'hE1, 8'h00};
    vt[5] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd3,  1'b0, 4'd0,  8'h77, 8'h00};
    vt[6] = '{1'b1, 4'd0,  8'h01, 1'b1, 4'd0,  1'b1, 4'd15, 8'h01, 8'hE1};

    idle_inputs();
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_busy", b16.Busy, 0);
    chk("rst_done", b16.Clr_Done, 0);
    chk("rst_drop", b16.W_Drop, 0);
    chk("rst_r0", b16.R0_Data, 0);
    Rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      b16.R0_en = 1; b16.R0_Addr = 4'(i);
      b16.R1_en = 1; b16.R1_Addr = 4'(15 - i);
      step();
      chk($sformatf("rst_rd0_%0d", i), b16.R0_Data, 0);
      chk($sformatf("rst_rd1_%0d", i), b16.R1_Data, 0);
    end
    chk("rst_busy2", b16.Busy, 0);

    for (int k = 0; k < 7; k++) begin
      b16.W_en = vt[k].w_en; b16.W_Addr = vt[k].w_addr;
      b16.W_Data = vt[k].w_data;
      b16.R0_en = vt[k].r0_en; b16.R0_Addr = vt[k].r0_addr;
      b16.R1_en = vt[k].r1_en; b16.R1_Addr = vt[k].r1_addr;
      step();
      chk($sformatf("vec%0d_r0", k), b16.R0_Data, vt[k].e0);
      chk($sformatf("vec%0d_r1", k), b16.R1_Data, vt[k].e1);
    end
    b16.W_en = 0; b16.R0_en = 0; b16.R1_en = 0;

    // Sweep with 0xA5; drop a write, ignore a second request.
    b16.Clr_Req = 1; b16.Clr_Data = 8'hA5;
    step();
    b16.Clr_Req = 0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int n = 0; n < 24; n++) begin
      if (b16.Busy) busy_cnt++;
      if (b16.Clr_Done) done_cnt++;
      if (n == 5) begin
        chk("sweep_bypass_r0", b16.R0_Data, 8'hA5);
        chk("sweep_stale_r1", b16.R1_Data, 8'hE1);
      end
      if (n == 11) chk("sweep_wdrop", b16.W_Drop, 1);
      if (n == 12) chk("sweep_wdrop_off", b16.W_Drop, 0);
      if (n == 16) chk("sweep_done_at16", b16.Clr_Done, 1);
      b16.R0_en = (n == 4); b16.R0_Addr = 4'd4;
      b16.R1_en = (n == 4); b16.R1_Addr = 4'd15;
      b16.W_en = (n == 10); b16.W_Addr = 4'd7; b16.W_Data = 8'h11;
      b16.Clr_Req = (n == 8); b16.Clr_Data = 8'h3C;
      step();
    end
    chk("sweep_busy_cycles", busy_cnt, 16);
    chk("sweep_done_count", done_cnt, 1);
    for (int a = 0; a < 16; a++) begin
      b16.Dbg_Addr = 4'(a);
      #1;
      chk($sformatf("sweep_dbg_%0d", a), b16.Dbg_Data, 8'hA5);
    end

    // 12-entry build: top entry and out-of-range address.
    b12.W_en = 1; b12.W_Addr = 4'd11; b12.W_Data = 8'h44;
    b12.R0_en = 1; b12.R0_Addr = 4'd11;
    step();
    chk("d12_wr11_r0", b12.R0_Data, 8'h44);
    b12.W_Addr = 4'd13; b12.W_Data = 8'h33;
    b12.R0_Addr = 4'd13; b12.R1_en = 1; b12.R1_Addr = 4'd11;
    step();
    chk("d12_rd13_r0", b12.R0_Data, 0);
    chk("d12_rd11_r1", b12.R1_Data, 8'h44);
    chk("d12_nodrop", b12.W_Drop, 0);
    b12.W_en = 0; b12.R0_en = 0; b12.R1_en = 0;
    for (int a = 0; a < 12; a++) begin
      b12.Dbg_Addr = 4'(a);
      #1;
      chk($sformatf("d12_dbg_%0d", a), b12.Dbg_Data,
          (a == 11) ? 8'h44 : 8'h00);
    end
    b12.Dbg_Addr = 4'd13;
    #1;
    chk("d12_dbg_oor", b12.Dbg_Data, 0);

    // Reset in the middle of a sweep, pointer at 5.
    step();
    b12.Clr_Req = 1; b12.Clr_Data = 8'h99;
    step();
    b12.Clr_Req = 0;
    repeat (5) step();
    chk("abort_busy_pre", b12.Busy, 1);
    Rst = 1'b1;
    #1;
    chk("abort_busy", b12.Busy, 0);
    chk("abort_done", b12.Clr_Done, 0);
    chk("abort_r1", b12.R1_Data, 0);
    for (int a = 0; a < 12; a++) begin
      b12.Dbg_Addr = 4'(a);
      #1;
      chk($sformatf("abort_dbg_%0d", a), b12.Dbg_Data, 0);
    end
    step();
    Rst = 1'b0;
    done_cnt = 0;
    for (int n = 0; n < 20; n++) begin
      if (b12.Clr_Done || b12.Busy) done_cnt++;
      step();
    end
    chk("abort_no_done", done_cnt, 0);

    b12.Clr_Req = 1; b12.Clr_Data = 8'h0F;
    step();
    b12.Clr_Req = 0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      if (b12.Busy) busy_cnt++;
      if (b12.Clr_Done) done_cnt++;
      step();
    end
    chk("d12_busy_cycles", busy_cnt, 12);
    chk("d12_done_count", done_cnt, 1);
    for (int a = 0; a < 12; a++) begin
      b12.Dbg_Addr = 4'(a);
      #1;
      chk($sformatf("d12_fill_%0d", a), b12.Dbg_Data, 8'h0F);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
